dev_reg_arbiter: RTL and testbench

DEV_REG_ARBITER -- requirements
Module: dev_reg_arbiter

---
 rtl/dev_reg_arbiter.sv | 136 +++++++++++++
 tb/tb_dev_reg_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dev_reg_arbiter.sv
// Four-requester arbiter guarding a small register bank; IDLE -> GRANT -> DONE per access.
// Define ARB_RR_EN for round-robin selection; fixed priority (req[0] highest) otherwise.
module dev_reg_arbiter #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      req,
  input  logic [3:0]      wr,
  input  logic [4*AW-1:0] addr,
  input  logic [4*DW-1:0] wdata,
  output logic [3:0]      gnt,
  output logic [3:0]      ack,
  output logic [DW-1:0]   rdata,
  output logic            busy
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

  state_t          state_reg, state_next;
  logic [3:0]      gnt_reg;
  logic            wr_reg;
  logic [AW-1:0]   addr_reg;
  logic [DW-1:0]   wdata_reg;
  logic [DW-1:0]   rdata_reg;
  logic [DW-1:0]   bank_reg [DEPTH];

  logic [1:0]      win_idx;
  logic [3:0]      win_onehot;
  logic [AW-1:0]   addr_sel  [4];
  logic [DW-1:0]   wdata_sel [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_unpack
      assign addr_sel[gi]  = addr[gi*AW +: AW];
      assign wdata_sel[gi] = wdata[gi*DW +: DW];
    end
  endgenerate

`ifdef ARB_RR_EN
  logic [1:0] ptr_reg;
  logic [1:0] cand;
  logic       found;

  // Search upward from the pointer; the 2-bit sum wraps naturally.
  always_comb begin
    win_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_reg + 2'(k);
      if (!found && req[cand]) begin
        win_idx = cand;
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (state_reg == IDLE && |req) begin
      ptr_reg <= win_idx + 2'd1;
    end
  end
`else
  always_comb begin
    win_idx = '0;
    for (int k = 3; k >= 0; k--) begin
      if (req[k]) win_idx = 2'(k);
    end
  end
`endif

  assign win_onehot = 4'b0001 << win_idx;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (|req) state_next = GRANT;
      GRANT:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields are captured once at grant so later input changes cannot leak in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      wr_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (|req) begin
            gnt_reg   <= win_onehot;
            wr_reg    <= wr[win_idx];
            addr_reg  <= addr_sel[win_idx];
            wdata_reg <= wdata_sel[win_idx];
          end
        end
        GRANT: begin
          if (!wr_reg) rdata_reg <= bank_reg[addr_reg];
        end
        DONE: gnt_reg <= '0;
        default: ;
      endcase
    end
  end

  // Bank must clear on reset, so it is built from registers rather than a RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        bank_reg[i] <= '0;
      end else if (state_reg == GRANT && wr_reg && addr_reg == AW'(i)) begin
        bank_reg[i] <= wdata_reg;
      end
    end
  end

  assign gnt   = gnt_reg;
  assign ack   = (state_reg == DONE) ? gnt_reg : 4'b0000;
  assign rdata = rdata_reg;
  assign busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_dev_reg_arbiter.sv
// Self-checking bench for dev_reg_arbiter: vector table, corner sequences, random traffic.
// Reference model is transaction level: a bank array, last-read value and RR pointer.
module tb_dev_reg_arbiter;
  localparam int DW = 8;
  localparam int AW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req, wr;
  logic [4*AW-1:0] addr;
  logic [4*DW-1:0] wdata;
  logic [3:0]      gnt, ack;
  logic [DW-1:0]   rdata;
  logic            busy;

  dev_reg_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_bank [1<<AW];
  logic [DW-1:0] m_rdata;
  int            m_ptr;

  typedef struct {
    logic [3:0] req;
    logic [3:0] wr;
    int         a;
    int         d;
    logic [3:0] exp_gnt;
    logic [7:0] exp_rd;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r);
`ifdef ARB_RR_EN
    for (int k = 0; k < 4; k++) if (r[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
`else
    for (int k = 0; k < 4; k++) if (r[k]) return k;
`endif
    return -1;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < (1<<AW); i++) m_bank[i] = '0;
    m_rdata = '0;
    m_ptr   = 0;
  endfunction

  task automatic do_reset();
    rst = 1'b1; req = '0; wr = '0; addr = '0; wdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Starts on a negedge with the DUT idle; ends on the negedge after DONE->IDLE.
  task automatic do_txn(input logic [3:0] r, input logic [3:0] w, input logic [4*AW-1:0] a,
                        input logic [4*DW-1:0] d, input bit scramble,
                        output logic [3:0] g_seen, output logic [DW-1:0] rd_seen);
    int win;
    logic [3:0] exp_g;
    logic [AW-1:0] ma;
    logic [DW-1:0] md;
    logic mw;
    chk("idle_before", busy, 1'b0);
    req = r; wr = w; addr = a; wdata = d;
    win   = pick(r);
    exp_g = 4'(1 << win);
    ma = a[win*AW +: AW];
    md = d[win*DW +: DW];
    mw = w[win];
    @(negedge clk);
    chk("gnt_grant", gnt, exp_g);
    chk("busy_grant", busy, 1'b1);
    chk("ack_early", ack, 4'b0000);
    g_seen = gnt;
    m_ptr = (win + 1) % 4;
    if (scramble) begin
      req = 4'($urandom); wr = 4'($urandom);
      addr = 12'($urandom); wdata = $urandom;
    end
    @(negedge clk);
    if (mw) m_bank[ma] = md;
    else    m_rdata = m_bank[ma];
    chk("ack_done", ack, exp_g);
    chk("gnt_done", gnt, exp_g);
    chk("rdata_done", rdata, m_rdata);
    rd_seen = rdata;
    @(negedge clk);
    chk("busy_after", busy, 1'b0);
    chk("gnt_after", gnt, 4'b0000);
    chk("ack_after", ack, 4'b0000);
    $display("txn req=%b win=%0d wr=%0b addr=%0d data=%h rdata=%h", r, win, mw, ma, md, rdata);
  endtask

  logic [3:0]      g_seen;
  logic [DW-1:0]   rd_seen;
  logic [4*AW-1:0] a_pk;
  logic [4*DW-1:0] d_pk;
  logic [3:0]      w_pk, r_pk;
  int              who, gap;
  int              exp_order [5];

  initial begin
    rst = 1'b1; req = '0; wr = '0; addr = '0; wdata = '0;
    model_reset();
    @(negedge clk);
    do_reset();
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_ack", ack, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdata", rdata, 8'h00);

    tbl[0] = '{4'b0010, 4'b0010, 3, 'hA5, 4'b0010, 8'h00};
    tbl[1] = '{4'b0010, 4'b0000, 3, 'h00, 4'b0010, 8'hA5};
    tbl[2] = '{4'b1000, 4'b1000, 7, 'h5A, 4'b1000, 8'hA5};
    tbl[3] = '{4'b0100, 4'b0100, 0, 'hFF, 4'b0100, 8'hA5};
    tbl[4] = '{4'b0001, 4'b0000, 7, 'h00, 4'b0001, 8'h5A};
    tbl[5] = '{4'b0100, 4'b0000, 0, 'h00, 4'b0100, 8'hFF};
    tbl[6] = '{4'b0001, 4'b0000, 3, 'h00, 4'b0001, 8'hA5};
    tbl[7] = '{4'b1000, 4'b0000, 1, 'h00, 4'b1000, 8'h00};
    for (int i = 0; i < 8; i++) begin
      who = 0;
      for (int k = 0; k < 4; k++) if (tbl[i].req[k]) who = k;
      a_pk = 12'($urandom);
      d_pk = $urandom;
      a_pk[who*AW +: AW] = AW'(tbl[i].a);
      d_pk[who*DW +: DW] = DW'(tbl[i].d);
      w_pk = (4'($urandom) & ~tbl[i].req) | tbl[i].wr;
      do_txn(tbl[i].req, w_pk, a_pk, d_pk, 1'b0, g_seen, rd_seen);
      chk("tbl_gnt", g_seen, tbl[i].exp_gnt);
      chk("tbl_rdata", rd_seen, tbl[i].exp_rd);
    end
    req = '0;
    @(negedge clk);
    chk("rdata_hold_idle", rdata, 8'h00);

    // Mid-flight reset during the GRANT cycle of a write.
    do_reset();
    req = 4'b0001; wr = 4'b0001; addr = 12'd5; wdata = 32'h3C;
    @(negedge clk);
    chk("mr_gnt", gnt, 4'b0001);
    rst = 1'b1; req = '0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("mr_ack", ack, 4'b0000);
    chk("mr_gnt_clr", gnt, 4'b0000);
    chk("mr_busy", busy, 1'b0);
    @(negedge clk);
    chk("mr_ack_late", ack, 4'b0000);
    a_pk = '0; a_pk[2*AW +: AW] = 3'd5;
    do_txn(4'b0100, 4'b0000, a_pk, '0, 1'b0, g_seen, rd_seen);
    chk("mr_bank5", rd_seen, 8'h00);

    // Inputs change during GRANT; captured values must win.
    a_pk = '0; a_pk[2*AW +: AW] = 3'd6;
    d_pk = '0; d_pk[2*DW +: DW] = 8'h77;
    do_txn(4'b0100, 4'b0100, a_pk, d_pk, 1'b1, g_seen, rd_seen);
    req = '0;
    @(negedge clk);
    do_txn(4'b0100, 4'b0000, a_pk, '0, 1'b0, g_seen, rd_seen);
    chk("holdoff_read", rd_seen, 8'h77);

    // Held contention: every request re-arbitrated at each IDLE.
    do_reset();
`ifdef ARB_RR_EN
    exp_order = '{0, 1, 2, 3, 0};
`else
    exp_order = '{0, 0, 0, 0, 0};
`endif
    for (int i = 0; i < 5; i++) begin
      do_txn(4'b1111, 4'b0000, '0, '0, 1'b0, g_seen, rd_seen);
      chk("order_1111", g_seen, 4'(1 << exp_order[i]));
    end
    do_reset();
`ifdef ARB_RR_EN
    exp_order = '{1, 3, 1, 3, 1};
`else
    exp_order = '{1, 1, 1, 1, 1};
`endif
    for (int i = 0; i < 5; i++) begin
      do_txn(4'b1010, 4'b0000, '0, '0, 1'b0, g_seen, rd_seen);
      chk("order_1010", g_seen, 4'(1 << exp_order[i]));
    end

    // Random traffic against the model, with idle gaps and GRANT-cycle scrambling.
    do_reset();
    for (int i = 0; i < 150; i++) begin
      r_pk = 4'($urandom_range(1, 15));
      do_txn(r_pk, 4'($urandom), 12'($urandom), $urandom, 1'b1, g_seen, rd_seen);
      gap = $urandom_range(0, 2);
      req = '0;
      for (int j = 0; j < gap; j++) begin
        @(negedge clk);
        chk("rnd_idle_busy", busy, 1'b0);
        chk("rnd_idle_rdata", rdata, m_rdata);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
